// File: rtl/mem_issue_queue.sv
// In-order issue queue for the memory functional unit: a circular FIFO of packed
// op records feeding a scheduler that keeps at most one op in flight.
module mem_issue_queue #(
   parameter int DEPTH = 4,
   parameter int PW    = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     enq_valid,
   input  logic [PW-1:0]            enq_payload,
   output logic                     enq_ready,
   input  logic                     unit_busy,
   input  logic                     stall,
   output logic                     issue_start,
   output logic [PW-1:0]            issue_payload,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      READY     = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PW-1:0]      mem_q [DEPTH];
   logic [PW-1:0]      mem_d [DEPTH];

   logic               enq_fire_s;
   logic               issue_fire_s;

   // Handshake and issue decision; both are blocked outright during a flush.
   always_comb begin
      enq_ready    = (count_q != CNT_W'(DEPTH)) && !flush;
      enq_fire_s   = enq_valid && enq_ready;
      issue_fire_s = (state_q == READY) && (count_q != {CNT_W{1'b0}})
                     && !unit_busy && !stall && !flush;
      issue_start  = issue_fire_s;
      count        = count_q;
      if (issue_fire_s) begin
         issue_payload = mem_q[head_q];
      end else begin
         issue_payload = {PW{1'b0}};
      end
   end

   // Entry storage: written at tail only; never cleared, pointers define validity.
   always_comb begin
      mem_d = mem_q;
      if (enq_fire_s && !rst) begin
         mem_d[tail_q] = enq_payload;
      end else begin
         mem_d = mem_q;
      end
   end

   // Pointer, occupancy and scheduler next-state; reset dominates flush.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rst || flush) begin
         state_d = READY;
         head_d  = {PTR_W{1'b0}};
         tail_d  = {PTR_W{1'b0}};
         count_d = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            READY: begin
               if (issue_fire_s) begin
                  state_d = WAIT_BUSY;
               end else begin
                  state_d = READY;
               end
            end
            // One cycle for the unit to raise its in-use flag after the start pulse.
            WAIT_BUSY: begin
               if (unit_busy) begin
                  state_d = WAIT_DONE;
               end else begin
                  state_d = READY;
               end
            end
            WAIT_DONE: begin
               if (!unit_busy) begin
                  state_d = READY;
               end else begin
                  state_d = WAIT_DONE;
               end
            end
            default: state_d = READY;
         endcase

         if (enq_fire_s) begin
            tail_d = tail_q + PTR_W'(1);
         end else begin
            tail_d = tail_q;
         end
         if (issue_fire_s) begin
            head_d = head_q + PTR_W'(1);
         end else begin
            head_d = head_q;
         end

         case ({enq_fire_s, issue_fire_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
   end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_mem_issue_queue;

   localparam int DEPTH = 4;
   localparam int PW    = 128;

   logic            clk = 1'b0;
   logic            rst, flush, enq_valid, unit_busy, stall;
   logic [PW-1:0]   enq_payload;
   logic            enq_ready, issue_start;
   logic [PW-1:0]   issue_payload;
   logic [2:0]      count;

   mem_issue_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_payload(enq_payload), .enq_ready(enq_ready),
      .unit_busy(unit_busy), .stall(stall),
      .issue_start(issue_start), .issue_payload(issue_payload), .count(count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference: list of queued ops plus "an op is in flight" flag, which
   // clears on the first edge after the issue where the unit is not busy.
   logic [PW-1:0] mq[$];
   bit            m_out;

   logic            smp_start, smp_rdy;
   logic [PW-1:0]   smp_pl;
   logic [2:0]      smp_cnt;

   typedef struct {
      logic          r, f, ev;
      logic [PW-1:0] pl;
      logic          bz, st;
      logic          e_start;
      logic [PW-1:0] e_pl;
      logic          e_rdy;
      logic [2:0]    e_cnt;
   } vec_t;
   vec_t tbl[19];

   task automatic cmp(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic f, input logic ev,
                        input logic [PW-1:0] pl, input logic bz, input logic st);
      bit            e_start, e_rdy;
      logic [PW-1:0] e_pl;
      int            e_cnt;
      rst = r; flush = f; enq_valid = ev; enq_payload = pl; unit_busy = bz; stall = st;
      @(negedge clk);
      e_start = !m_out && (mq.size() != 0) && !bz && !st && !f;
      e_pl    = e_start ? mq[0] : '0;
      e_rdy   = (mq.size() != DEPTH) && !f;
      e_cnt   = mq.size();
      smp_start = issue_start; smp_pl = issue_payload; smp_rdy = enq_ready; smp_cnt = count;
      cmp("model_issue_start", {127'd0, issue_start}, {127'd0, e_start});
      cmp("model_issue_payload", issue_payload, e_pl);
      cmp("model_enq_ready", {127'd0, enq_ready}, {127'd0, e_rdy});
      cmp("model_count", {125'd0, count}, PW'(e_cnt));
      @(posedge clk);
      if (r || f) begin
         mq.delete();
         m_out = 1'b0;
      end else begin
         if (e_start) begin
            void'(mq.pop_front());
            m_out = 1'b1;
         end else if (m_out && !bz) begin
            m_out = 1'b0;
         end
         if (ev && e_rdy) mq.push_back(pl);
      end
      #1;
   endtask

   task automatic idle(input logic bz);
      apply(1'b0, 1'b0, 1'b0, '0, bz, 1'b0);
   endtask

   initial begin
      int got;
      int sent;
      logic [PW-1:0] rp;

      //            r     f     ev    pl         bz    st    start pl         rdy   cnt
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 128'h55, 1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 3'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 128'hA1, 1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 3'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 128'hB2, 1'b0, 1'b0, 1'b1, 128'hA1, 1'b1, 3'd1};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 3'd1};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 128'hC3, 1'b1, 1'b0, 1'b0, 128'h0,  1'b1, 3'd1};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 128'hD4, 1'b1, 1'b0, 1'b0, 128'h0,  1'b1, 3'd2};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 128'hE5, 1'b1, 1'b0, 1'b0, 128'h0,  1'b1, 3'd3};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 128'hF6, 1'b1, 1'b0, 1'b0, 128'h0,  1'b0, 3'd4};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b1, 128'hB2, 1'b0, 3'd4};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 128'h0,  1'b1, 3'd3};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 128'h0,  1'b1, 3'd3};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 3'd3};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b1, 128'hC3, 1'b1, 3'd3};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 3'd2};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b1, 128'hD4, 1'b1, 3'd2};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 128'h0,  1'b1, 3'd1};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 3'd1};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b1, 128'hE5, 1'b1, 3'd1};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b0, 128'h0,  1'b1, 3'd0};

      rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_payload = '0; unit_busy = 1'b0; stall = 1'b0;
      m_out = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // basic issue and back-pressure
      for (int i = 0; i < 19; i++) begin
         apply(tbl[i].r, tbl[i].f, tbl[i].ev, tbl[i].pl, tbl[i].bz, tbl[i].st);
         cmp("tbl_issue_start", {127'd0, smp_start}, {127'd0, tbl[i].e_start});
         cmp("tbl_issue_payload", smp_pl, tbl[i].e_pl);
         cmp("tbl_enq_ready", {127'd0, smp_rdy}, {127'd0, tbl[i].e_rdy});
         cmp("tbl_count", {125'd0, smp_cnt}, {125'd0, tbl[i].e_cnt});
      end

      // stall holds issue for three cycles
      apply(1'b0, 1'b0, 1'b1, 128'h77, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
         cmp("stall_hold", {127'd0, smp_start}, 128'd0);
      end
      idle(1'b0);
      cmp("stall_release", {127'd0, smp_start}, 128'd1);
      cmp("stall_release_pl", smp_pl, 128'h77);
      idle(1'b0);

      // flush with three queued ops while waiting on the unit
      apply(1'b0, 1'b0, 1'b1, 128'h101, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b1, 128'h102, 1'b0, 1'b0);
      cmp("flush_pre_issue", smp_pl, 128'h101);
      apply(1'b0, 1'b0, 1'b1, 128'h103, 1'b1, 1'b0);
      apply(1'b0, 1'b0, 1'b1, 128'h104, 1'b1, 1'b0);
      apply(1'b0, 1'b1, 1'b1, 128'h105, 1'b1, 1'b0);
      cmp("flush_cnt_before", {125'd0, smp_cnt}, 128'd3);
      cmp("flush_no_start", {127'd0, smp_start}, 128'd0);
      cmp("flush_enq_blocked", {127'd0, smp_rdy}, 128'd0);
      apply(1'b0, 1'b0, 1'b1, 128'h106, 1'b0, 1'b0);
      cmp("flush_cnt_after", {125'd0, smp_cnt}, 128'd0);
      cmp("flush_ready_after", {127'd0, smp_rdy}, 128'd1);
      idle(1'b0);
      cmp("flush_new_issue", {127'd0, smp_start}, 128'd1);
      cmp("flush_new_pl", smp_pl, 128'h106);
      idle(1'b0);

      // reset in the middle of an operation
      apply(1'b0, 1'b0, 1'b1, 128'h201, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b1, 128'h202, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b1, 128'h203, 1'b1, 1'b0);
      apply(1'b1, 1'b0, 1'b1, 128'h204, 1'b1, 1'b0);
      cmp("rst_cnt_before", {125'd0, smp_cnt}, 128'd2);
      apply(1'b0, 1'b0, 1'b1, 128'h205, 1'b0, 1'b0);
      cmp("rst_cnt_after", {125'd0, smp_cnt}, 128'd0);
      cmp("rst_start_after", {127'd0, smp_start}, 128'd0);
      cmp("rst_ready_after", {127'd0, smp_rdy}, 128'd1);
      cmp("rst_pl_after", smp_pl, 128'd0);
      idle(1'b0);
      cmp("rst_then_issue", smp_pl, 128'h205);
      idle(1'b0);

      // ten ops streamed across pointer wrap
      got = 0;
      sent = 0;
      for (int c = 0; c < 60 && got < 10; c++) begin
         if (sent < 10 && mq.size() < DEPTH) begin
            apply(1'b0, 1'b0, 1'b1, PW'(32'h300 + sent), 1'b0, 1'b0);
            sent++;
         end else begin
            idle(1'b0);
         end
         cmp("wrap_cnt_le_depth", {127'd0, (smp_cnt <= 3'd4)}, 128'd1);
         if (smp_start === 1'b1) begin
            cmp("wrap_order", smp_pl, PW'(32'h300 + got));
            got++;
         end
      end
      cmp("wrap_all_issued", PW'(got), 128'd10);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         rp = {$urandom, $urandom, $urandom, $urandom};
         apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
               $urandom_range(0, 1) == 1, rp,
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
